wb_stage: RTL
=============

Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback-data formation for the pipelined CPU.
- It is the writer-side driver of the general-purpose register file's write port, and the only source of reg_write, num_write and data_write.
- Latches MEM-stage results and selects the writeback source: ALU result, extracted load data, or link address.
- Applies stall and flush, suppresses writes to r0, and counts retired instructions.

Parameters:
- DW, 32, datapath width. Only 32 is supported.
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- stall  in  1  hold the WB register contents.
- flush  in  1  load a bubble into the WB register.
- m_valid  in  1  MEM-stage slot holds a real instruction.
- m_reg_write  in  1  instruction writes a GPR.
- m_num_write  in  5  destination register number.
- m_wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 link, 11 treated as ALU.
- m_load_type  in  3  load format: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others treated as lw.
- m_alu_result  in  DW  ALU result; also the memory address for loads.
- m_mem_rdata  in  DW  raw 32-bit word read from data memory.
- m_pc  in  DW  PC of the MEM-stage instruction.
- reg_write  out  1  GPR write enable.
- num_write  out  5  GPR write address.
- data_write  out  DW  GPR write data.
- retired  out  RETIRE_W  count of instructions captured into WB.

Behaviour:
- Reset (resetn=0, asynchronous):
  - WB valid=0, reg_write=0, num_write=0, data_write=0, retired=0.
  - Reset may assert mid-stall; all state clears regardless.
- Capture priority each rising edge: flush > stall > normal.
  - flush=1: valid<=0; num_write and data_write may hold; retired unchanged.
  - stall=1 (flush=0): every WB field holds; retired unchanged. A held GPR write repeats each cycle with identical data, which is harmless.
  - Normal: valid<=m_valid and every field is captured; retired increments by 1 if m_valid=1.
- Latency: exactly one cycle from MEM inputs to the WB outputs. All outputs are driven from registers; there is no combinational path from inputs to outputs.
- reg_write = valid & captured m_reg_write & (num_write != 0). A destination of r0 never asserts reg_write.
- Data formation, computed combinationally before the register and captured:
  - wb_sel 00 or 11: m_alu_result.
  - wb_sel 10: m_pc + 8, modulo 2^32 (0xFFFFFFFC -> 0x00000004).
  - wb_sel 01: load extraction.
- Load extraction: little-endian byte lanes selected by addr = m_alu_result[1:0].
  - lw: full word; addr ignored.
  - lb / lbu: byte at bits [8*addr+7 : 8*addr], sign- or zero-extended to 32 bits.
  - lh / lhu: halfword at bits [16*addr[1]+15 : 16*addr[1]]; addr[0] ignored with no exception; sign- or zero-extended.
- retired wraps from all-ones to 0.
- Invalid slot (m_valid=0) captured: reg_write=0; data fields are don't-care.
- stall and flush together: flush wins.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: adds three outputs for EXE-stage forwarding:
  - fwd_valid (1) = reg_write.
  - fwd_num (5) = num_write.
  - fwd_data (DW) = data_write.
  - All three are pure copies of the registered values, with no added logic depth.
- Undefined: these ports do not exist and the logic is otherwise identical.

Test Plan:
- Reset: hold resetn=0 with random inputs -> reg_write=0, num_write=0, data_write=0, retired=0. Release, then a valid lw of 0xDEADBEEF to r5 -> next cycle reg_write=1, num_write=5, data_write=0xDEADBEEF, retired=1.
- Load extraction: m_mem_rdata=0x80FF7F01, wb_sel=01.
  - lb addr 3 -> 0xFFFFFF80.
  - lbu addr 3 -> 0x00000080.
  - lb addr 1 -> 0x0000007F.
  - lh addr 2 -> 0xFFFF80FF.
  - lhu addr 1 -> 0x00007F01.
- Link: wb_sel=10, m_pc=0x00400010, dest r31 -> data_write=0x00400018. With m_pc=0xFFFFFFFC -> data_write=0x00000004.
- r0 suppression: valid ALU write to r0 with result 0x12345678 -> reg_write=0, retired still increments.
- Stall/flush: capture a write to r8; hold stall=1 for 3 cycles with changing inputs -> outputs constant, retired unchanged. Assert stall and flush together -> reg_write=0 next cycle, retired unchanged.
- Counter wrap and forwarding:
  - Preload retired to 0xFFFFFFFF via 2^32-1 valid captures, or a backdoor force -> next valid capture gives retired=0.
  - With WB_FWD_EN defined, fwd_valid, fwd_num and fwd_data equal reg_write, num_write and data_write every cycle.

Source files
------------

// File: rtl/wb_stage.sv
// MEM/WB pipeline register: selects ALU/load/link writeback data, applies stall/flush,
// blocks r0 writes and counts retired instructions. Define WB_FWD_EN for EXE forwarding taps.
module wb_stage #(
    parameter int DW       = 32,
    parameter int RETIRE_W = 32
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                stall,
    input  logic                flush,
    input  logic                m_valid,
    input  logic                m_reg_write,
    input  logic [4:0]          m_num_write,
    input  logic [1:0]          m_wb_sel,
    input  logic [2:0]          m_load_type,
    input  logic [DW-1:0]       m_alu_result,
    input  logic [DW-1:0]       m_mem_rdata,
    input  logic [DW-1:0]       m_pc,
    output logic                reg_write,
    output logic [4:0]          num_write,
    output logic [DW-1:0]       data_write,
    output logic [RETIRE_W-1:0] retired
`ifdef WB_FWD_EN
    ,
    output logic                fwd_valid,
    output logic [4:0]          fwd_num,
    output logic [DW-1:0]       fwd_data
`endif
);

    // Slot semantics: m_valid qualifies the MEM slot; a captured slot is accepted
    // unless stall holds the register or flush replaces it with a bubble.
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] load_data;
    logic [DW-1:0] wb_data;

    always_comb begin
        byte_sel  = m_mem_rdata[7:0];
        half_sel  = m_mem_rdata[15:0];
        load_data = m_mem_rdata;
        wb_data   = m_alu_result;

        case (m_alu_result[1:0])
            2'd1:    byte_sel = m_mem_rdata[15:8];
            2'd2:    byte_sel = m_mem_rdata[23:16];
            2'd3:    byte_sel = m_mem_rdata[31:24];
            default: byte_sel = m_mem_rdata[7:0];
        endcase

        // Halfword lane uses addr[1] only; a misaligned addr[0] is silently ignored.
        if (m_alu_result[1])
            half_sel = m_mem_rdata[31:16];

        case (m_load_type)
            3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  load_data = {24'd0, byte_sel};
            3'b011:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {16'd0, half_sel};
            default: load_data = m_mem_rdata;
        endcase

        case (m_wb_sel)
            2'b01:   wb_data = load_data;
            2'b10:   wb_data = m_pc + DW'(8);
            default: wb_data = m_alu_result;
        endcase
    end

    // reg_write is registered already qualified by valid and r0, so no output logic follows the flops.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            reg_write  <= 1'b0;
            num_write  <= 5'd0;
            data_write <= '0;
            retired    <= '0;
        end else if (flush) begin
            reg_write  <= 1'b0;
        end else if (!stall) begin
            reg_write  <= m_valid & m_reg_write & (m_num_write != 5'd0);
            num_write  <= m_num_write;
            data_write <= wb_data;
            if (m_valid)
                retired <= retired + RETIRE_W'(1);
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = reg_write;
    assign fwd_num   = num_write;
    assign fwd_data  = data_write;
`endif

endmodule
